video_fetch: RTL and testbench
==============================

VIDEO_FETCH -- requirements
Module: video_fetch

Interface
REQ-001 SHALL have port CLOCK_32  in  1  sole clock, 32 MHz; all flops on its rising edge.
REQ-002 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have port de  in  1  display enable, synchronous to CLOCK_32.
REQ-004 SHALL have port vsync  in  1  vertical sync, active-high.
REQ-005 SHALL have port cs  in  1  register select, active-low.
REQ-006 SHALL have port rw  in  1  1 = read, 0 = write.
REQ-007 SHALL have port addr  in  3  register index.
REQ-008 SHALL have port data  in  16  CPU write data.
REQ-009 SHALL have port data_out  out  16  CPU read data.
REQ-010 SHALL have port oe  out  1  read drive enable, equal to !cs && rw.
REQ-011 SHALL have port mem_req  out  1  RAM word request.
REQ-012 SHALL have port mem_addr  out  21  RAM word address, byte address bits [21:1].
REQ-013 SHALL have port mem_ack  in  1  one-cycle RAM data-valid strobe.
REQ-014 SHALL have port mem_data  in  16  RAM read data.
REQ-015 SHALL have port load  out  1  shifter load strobe, active-low; the shifter latches on its rising edge.
REQ-016 SHALL have port shifter_data  out  16  word presented to the shifter.

Function
REQ-017 SHALL run a free slot counter 0..15 that wraps 15->0; one shifter word per slot.
REQ-018 SHALL implement FSM states IDLE, REQ, HOLD, LOAD and UNDER.
REQ-019 IDLE: at slot 0 with de=1, SHALL go to REQ, assert mem_req and drive mem_addr = vcount[21:1].
REQ-020 REQ: mem_req SHALL stay high until mem_ack; on mem_ack, latch mem_data into shifter_data, add 2 to vcount (22-bit, wraps to 0) and go to HOLD.
REQ-021 REQ: if slot 8 is reached with no mem_ack, SHALL drop mem_req, set shifter_data = 0, set the sticky underrun flag, leave vcount unchanged and go to UNDER.
REQ-022 HOLD/UNDER: at slot 10 SHALL drive load low and go to LOAD.
REQ-023 LOAD: load SHALL be low for slots 10-13 and return high at slot 14; the FSM SHALL return to IDLE at slot 15.
REQ-024 shifter_data SHALL stay stable from slot 10 through slot 15.
REQ-025 de falling mid-slot SHALL NOT abort the slot; the slot completes.
REQ-026 A rising edge of vsync SHALL load vcount from base; if it coincides with a mem_ack, the reload wins over the increment.
REQ-027 Writes occur when cs=0 and rw=0: addr 0 -> base[21:16]=data[5:0]; addr 1 -> base[15:8]=data[7:0]; addr 5 -> any write clears underrun.
REQ-028 Reads: addr 0/1 -> base fields; addr 2 -> vcount[21:16]; addr 3 -> vcount[15:8]; addr 6 -> vcount[7:0]; addr 5 -> bit0 underrun; all other addresses and unused bits read 0.
REQ-029 A write to base SHALL NOT affect vcount until the next vsync rising edge.

Reset
REQ-030 reset SHALL force: FSM to IDLE, slot=0, mem_req=0, load=1, shifter_data=0, base=0, vcount=0, underrun=0.
REQ-031 reset asserted mid-fetch SHALL abandon the request immediately; a mem_ack arriving while reset is asserted SHALL be ignored.

Configuration
REQ-032 Macro VIDEO_FETCH_BASE_LO_EN SHALL add a writable base[7:1] at addr 4 from data[7:1], readable at addr 4.
REQ-033 Without VIDEO_FETCH_BASE_LO_EN, base[7:0] SHALL be constant 0, addr 4 writes ignored and addr 4 reads 0.

Structure
REQ-034 Package video_fetch_pkg SHALL hold the FSM state enum, register address constants, and the slot length and slot-number constants 0/8/10/14/15.
REQ-035 The slot counter SHALL be a sub-module named fetch_slot_timer.

Verification
REQ-036 Program base 0x07, 0x80, pulse vsync, hold de high, ack at slot 3 with 0xA5A5 -> mem_addr=0x03C000, load low slots 10-13, shifter_data=0xA5A5, vcount=0x078002.
REQ-037 Four consecutive slots with de high -> mem_addr sequence 0x03C000..0x03C003, four load rising edges 16 clocks apart.
REQ-038 Withhold mem_ack -> mem_req drops at slot 8, shifter_data=0, load still pulses, addr 5 reads 0x0001, and a write to addr 5 clears it.
REQ-039 vsync rising edge on the same cycle as mem_ack -> vcount equals base, not base+2.
REQ-040 reset asserted during REQ -> mem_req=0 and load=1 next cycle, vcount=0; with VIDEO_FETCH_BASE_LO_EN, addr 4 write 0x00FE reads back 0x00FE.

Source files
------------

// File: rtl/video_fetch_pkg.sv
// ---------------------------------------------------------------------------
// video_fetch_pkg
// Shared types and constants for the video word fetcher:
//   - fetch_state_e : fetch FSM states
//   - ADDR_*        : CPU register indices
//   - SLOT_*        : slot counter length and the slot numbers the FSM keys on
//   - slot_succ()   : slot counter successor (wraps 15 -> 0)
// ---------------------------------------------------------------------------
package video_fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_HOLD  = 3'd2,
        ST_LOAD  = 3'd3,
        ST_UNDER = 3'd4
    } fetch_state_e;

    // CPU register map
    localparam logic [2:0] ADDR_BASE_HI  = 3'd0;  // base[21:16]
    localparam logic [2:0] ADDR_BASE_MID = 3'd1;  // base[15:8]
    localparam logic [2:0] ADDR_VC_HI    = 3'd2;  // vcount[21:16]
    localparam logic [2:0] ADDR_VC_MID   = 3'd3;  // vcount[15:8]
    localparam logic [2:0] ADDR_BASE_LO  = 3'd4;  // base[7:1] (optional)
    localparam logic [2:0] ADDR_STATUS   = 3'd5;  // bit0 underrun
    localparam logic [2:0] ADDR_VC_LO    = 3'd6;  // vcount[7:0]

    // Slot timing
    localparam int SLOT_LEN = 16;
    localparam int SLOT_W   = 4;

    localparam logic [SLOT_W-1:0] SLOT_START    = 4'd0;
    localparam logic [SLOT_W-1:0] SLOT_TIMEOUT  = 4'd8;
    localparam logic [SLOT_W-1:0] SLOT_LOAD     = 4'd10;
    localparam logic [SLOT_W-1:0] SLOT_LOAD_END = 4'd14;
    localparam logic [SLOT_W-1:0] SLOT_LAST     = 4'd15;

    function automatic logic [SLOT_W-1:0] slot_succ(input logic [SLOT_W-1:0] s);
        return (s == SLOT_LAST) ? SLOT_START : s + 4'd1;
    endfunction

endpackage

// File: rtl/fetch_slot_timer.sv
// ---------------------------------------------------------------------------
// fetch_slot_timer
// Free-running slot counter 0..15; one shifter word is produced per slot.
// Ports:
//   clk_i      : clock
//   rst_i      : asynchronous active-high reset (counter -> 0)
//   slot_o     : current slot number
//   slot_nxt_o : slot number after the next rising edge; the FSM uses it so
//                its registered outputs change exactly as the slot changes
// ---------------------------------------------------------------------------
module fetch_slot_timer
    import video_fetch_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    output logic [SLOT_W-1:0] slot_o,
    output logic [SLOT_W-1:0] slot_nxt_o
);

    logic [SLOT_W-1:0] slot_q;
    logic [SLOT_W-1:0] slot_d;

    assign slot_d = slot_succ(slot_q);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            slot_q <= SLOT_START;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign slot_o     = slot_q;
    assign slot_nxt_o = slot_d;

endmodule

// File: rtl/video_fetch.sv
// ---------------------------------------------------------------------------
// video_fetch
// Fetches one 16-bit video word from RAM per 16-clock slot and hands it to
// the pixel shifter. A per-frame video counter (vcount) is reloaded from a
// CPU-programmed base on every rising edge of vsync and advances by 2 bytes
// per fetched word. A fetch that is not acknowledged by slot 8 is abandoned,
// a zero word is shifted instead and a sticky underrun flag is raised.
//
// Ports:
//   CLOCK_32     : 32 MHz clock, all flops on rising edge
//   reset        : asynchronous active-high reset
//   de           : display enable (sampled only when a new slot starts)
//   vsync        : vertical sync, rising edge reloads vcount from base
//   cs/rw/addr   : CPU register select (active-low), 1=read, register index
//   data         : CPU write data
//   data_out/oe  : CPU read data and its drive enable (!cs && rw)
//   mem_req      : RAM word request, mem_addr = vcount[21:1]
//   mem_ack      : one-cycle RAM data strobe, mem_data = read word
//   load         : active-low shifter load strobe (low slots 10..13)
//   shifter_data : word presented to the shifter
//
// Configuration:
//   VIDEO_FETCH_BASE_LO_EN : adds writable base[7:1] at register 4; when
//                            undefined base[7:0] is constant zero.
// ---------------------------------------------------------------------------
module video_fetch
    import video_fetch_pkg::*;
(
    input  logic        CLOCK_32,
    input  logic        reset,
    input  logic        de,
    input  logic        vsync,
    input  logic        cs,
    input  logic        rw,
    input  logic [2:0]  addr,
    input  logic [15:0] data,
    output logic [15:0] data_out,
    output logic        oe,
    output logic        mem_req,
    output logic [20:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_data,
    output logic        load,
    output logic [15:0] shifter_data
);

    // ------------------------------------------------------------------
    // Slot timing
    // ------------------------------------------------------------------
    logic [SLOT_W-1:0] slot;
    logic [SLOT_W-1:0] slot_nxt;

    fetch_slot_timer u_slot (
        .clk_i      (CLOCK_32),
        .rst_i      (reset),
        .slot_o     (slot),
        .slot_nxt_o (slot_nxt)
    );

    // ------------------------------------------------------------------
    // CPU registers
    // ------------------------------------------------------------------
    logic        wr_en;
    logic [5:0]  base_hi_q;
    logic [7:0]  base_mid_q;
    logic [7:0]  base_lo;
    logic [20:0] base_word;

    assign wr_en = !cs && !rw;

    always_ff @(posedge CLOCK_32 or posedge reset) begin
        if (reset) begin
            base_hi_q  <= '0;
            base_mid_q <= '0;
        end else if (wr_en) begin
            case (addr)
                ADDR_BASE_HI:  base_hi_q  <= data[5:0];
                ADDR_BASE_MID: base_mid_q <= data[7:0];
                default: ;
            endcase
        end
    end

`ifdef VIDEO_FETCH_BASE_LO_EN
    logic [6:0] base_lo_q;   // base[7:1]; base[0] is always 0 (word aligned)

    always_ff @(posedge CLOCK_32 or posedge reset) begin
        if (reset) begin
            base_lo_q <= '0;
        end else if (wr_en && addr == ADDR_BASE_LO) begin
            base_lo_q <= data[7:1];
        end
    end

    assign base_lo = {base_lo_q, 1'b0};
`else
    assign base_lo = 8'h00;
`endif

    // Word address form of base (byte bits [21:1])
    assign base_word = {base_hi_q, base_mid_q, base_lo[7:1]};

    // ------------------------------------------------------------------
    // Fetch FSM, video counter and underrun flag
    // vcount is held as a word address (byte bits [21:1]); byte bit 0 is
    // always zero because base is word aligned and steps are 2 bytes.
    // ------------------------------------------------------------------
    fetch_state_e state_q;
    logic         mem_req_q;
    logic [20:0]  mem_addr_q;
    logic         load_q;
    logic [15:0]  shifter_q;
    logic [20:0]  vcount_q;
    logic         underrun_q;
    logic         vsync_q;
    logic         vsync_rise;

    assign vsync_rise = vsync && !vsync_q;

    always_ff @(posedge CLOCK_32 or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            load_q     <= 1'b1;
            shifter_q  <= '0;
            vcount_q   <= '0;
            underrun_q <= 1'b0;
            vsync_q    <= 1'b0;
        end else begin
            vsync_q <= vsync;

            if (wr_en && addr == ADDR_STATUS) begin
                underrun_q <= 1'b0;
            end

            // Decisions look at slot_nxt so that every registered output
            // is valid for the whole of the slot it is named after.
            case (state_q)
                ST_IDLE: begin
                    if (slot_nxt == SLOT_START && de) begin
                        state_q    <= ST_REQ;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= vcount_q;
                    end
                end
                ST_REQ: begin
                    if (mem_ack) begin
                        state_q   <= ST_HOLD;
                        mem_req_q <= 1'b0;
                        shifter_q <= mem_data;
                        vcount_q  <= vcount_q + 21'd1;
                    end else if (slot_nxt == SLOT_TIMEOUT) begin
                        // RAM too slow: shift blanks this slot, keep vcount
                        state_q    <= ST_UNDER;
                        mem_req_q  <= 1'b0;
                        shifter_q  <= '0;
                        underrun_q <= 1'b1;
                    end
                end
                ST_HOLD, ST_UNDER: begin
                    if (slot_nxt == SLOT_LOAD) begin
                        state_q <= ST_LOAD;
                        load_q  <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (slot_nxt == SLOT_LOAD_END) begin
                        load_q <= 1'b1;
                    end
                    if (slot_nxt == SLOT_LAST) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            // Last assignment wins: a vsync reload beats a same-cycle step
            if (vsync_rise) begin
                vcount_q <= base_word;
            end
        end
    end

    assign mem_req      = mem_req_q;
    assign mem_addr     = mem_addr_q;
    assign load         = load_q;
    assign shifter_data = shifter_q;

    // ------------------------------------------------------------------
    // CPU read mux
    // ------------------------------------------------------------------
    logic [15:0] rd_data;

    always_comb begin
        rd_data = '0;
        case (addr)
            ADDR_BASE_HI:  rd_data[5:0] = base_hi_q;
            ADDR_BASE_MID: rd_data[7:0] = base_mid_q;
            ADDR_VC_HI:    rd_data[5:0] = vcount_q[20:15];
            ADDR_VC_MID:   rd_data[7:0] = vcount_q[14:7];
            ADDR_BASE_LO:  rd_data[7:0] = base_lo;
            ADDR_STATUS:   rd_data[0]   = underrun_q;
            ADDR_VC_LO:    rd_data[7:0] = {vcount_q[6:0], 1'b0};
            default: ;
        endcase
    end

    assign data_out = rd_data;
    assign oe       = !cs && rw;

    // Upper write-data byte has no register behind it, and the slot
    // number itself only matters through slot_nxt.
    logic unused_ok;
    assign unused_ok = ^{data[15:8], slot};

endmodule

// File: tb/tb_video_fetch.sv
module tb_video_fetch;

    logic        CLOCK_32 = 1'b0;
    logic        reset    = 1'b1;
    logic        de       = 1'b0;
    logic        vsync    = 1'b0;
    logic        cs       = 1'b1;
    logic        rw       = 1'b1;
    logic [2:0]  addr     = 3'd0;
    logic [15:0] data     = 16'h0;
    logic        mem_ack  = 1'b0;
    logic [15:0] mem_data = 16'h0;
    logic [15:0] data_out;
    logic        oe;
    logic        mem_req;
    logic [20:0] mem_addr;
    logic        load;
    logic [15:0] shifter_data;

`ifdef VIDEO_FETCH_BASE_LO_EN
    localparam bit LO_EN = 1'b1;
`else
    localparam bit LO_EN = 1'b0;
`endif

    video_fetch dut (
        .CLOCK_32     (CLOCK_32),
        .reset        (reset),
        .de           (de),
        .vsync        (vsync),
        .cs           (cs),
        .rw           (rw),
        .addr         (addr),
        .data         (data),
        .data_out     (data_out),
        .oe           (oe),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_data     (mem_data),
        .load         (load),
        .shifter_data (shifter_data)
    );

    always #5 CLOCK_32 = ~CLOCK_32;

    int n_chk  = 0;
    int n_fail = 0;
    int slot   = 0;   // bench's own view of the slot number

    // Reference model state (byte addresses, plain integers)
    int unsigned m_vc    = 0;
    int unsigned m_base  = 0;
    logic [15:0] m_sh    = 16'h0;
    bit          m_under = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_32);
        #1;
        if (!reset) slot = (slot + 1) % 16;
    endtask

    function automatic logic [15:0] exp_rd(input int a);
        case (a)
            0: return 16'((m_base >> 16) & 32'h3F);
            1: return 16'((m_base >> 8) & 32'hFF);
            2: return 16'((m_vc >> 16) & 32'h3F);
            3: return 16'((m_vc >> 8) & 32'hFF);
            4: return 16'(m_base & 32'hFF);
            5: return {15'd0, m_under};
            6: return 16'(m_vc & 32'hFF);
            default: return 16'h0;
        endcase
    endfunction

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        de = 1'b0; cs = 1'b0; rw = 1'b0; addr = a; data = d;
        tick();
        cs = 1'b1; rw = 1'b1;
        case (a)
            3'd0: m_base = (m_base & 32'h00FFFF) | ((32'(d) & 32'h3F) << 16);
            3'd1: m_base = (m_base & 32'h3F00FF) | ((32'(d) & 32'hFF) << 8);
            3'd4: if (LO_EN) m_base = (m_base & 32'h3FFF00) | (32'(d) & 32'hFE);
            3'd5: m_under = 1'b0;
            default: ;
        endcase
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] a, input logic [15:0] exp);
        de = 1'b0; cs = 1'b0; rw = 1'b1; addr = a;
        #1;
        chk({tag, " oe"}, 32'(oe), 32'd1);
        chk(tag, 32'(data_out), 32'(exp));
        cs = 1'b1;
        tick();
    endtask

    task automatic vs_pulse();
        de = 1'b0; vsync = 1'b1;
        tick();
        vsync = 1'b0;
        m_vc = m_base;
        tick();
    endtask

    task automatic goto15();
        de = 1'b0;
        while (slot != 15) tick();
    endtask

    // One full 16-clock slot, entered and left at slot 15.
    // ack_slot/vs_slot < 0 means "not driven".
    task automatic run_period(input bit de_v, input int ack_slot, input int vs_slot,
                              input logic [15:0] d);
        bit          fetch;
        int          a;
        int unsigned exp_addr;
        bit          exp_req;
        bit          exp_load;
        goto15();
        fetch    = de_v;
        a        = (fetch && ack_slot >= 0 && ack_slot <= 7) ? ack_slot : -1;
        exp_addr = m_vc >> 1;
        de = de_v; mem_ack = 1'b0; vsync = 1'b0;
        tick();
        for (int k = 0; k < 16; k++) begin
            exp_req  = fetch && (k <= ((a >= 0) ? a : 7));
            exp_load = !(fetch && k >= 10 && k <= 13);
            chk($sformatf("mem_req s%0d", k), 32'(mem_req), 32'(exp_req));
            chk($sformatf("load s%0d", k), 32'(load), 32'(exp_load));
            if (fetch && k == 0) chk("mem_addr", 32'(mem_addr), exp_addr);
            if (k == 10 || k == 15) chk($sformatf("shifter s%0d", k), 32'(shifter_data), 32'(m_sh));
            if (k < 15) begin
                mem_ack  = (k == ack_slot);
                mem_data = (k == ack_slot) ? d : 16'($urandom);
                vsync    = (k == vs_slot);
                if (k < 14) de = 1'($urandom_range(0, 1));
                // model: step on accepted ack, then a same-cycle reload overrides
                if (k == a) begin
                    m_sh = d;
                    m_vc = (m_vc + 2) & 32'h3FFFFF;
                end
                if (fetch && a < 0 && k == 7) begin
                    m_sh    = 16'h0;
                    m_under = 1'b1;
                end
                if (k == vs_slot) m_vc = m_base;
                tick();
            end
        end
        mem_ack = 1'b0;
        vsync   = 1'b0;
    endtask

    task automatic rd_all(input string tag);
        for (int i = 0; i < 8; i++) rd_chk($sformatf("%s r%0d", tag, i), 3'(i), exp_rd(i));
    endtask

    initial begin
        // ---------------- reset state ----------------
        tick();
        chk("rst mem_req", 32'(mem_req), 32'd0);
        chk("rst load", 32'(load), 32'd1);
        chk("rst shifter", 32'(shifter_data), 32'd0);
        chk("rst mem_addr", 32'(mem_addr), 32'd0);
        rd_all("rst");
        chk("oe idle", 32'(oe), 32'd0);
        reset = 1'b0;
        slot  = 0;

        // ---------------- basic fetch, ack at slot 3 ----------------
        wr(3'd0, 16'h0007);
        wr(3'd1, 16'h0080);
        vs_pulse();
        run_period(1'b1, 3, -1, 16'hA5A5);
        chk("basic mem_addr", 32'(mem_addr), 32'h03C000);
        chk("basic shifter", 32'(shifter_data), 32'hA5A5);
        rd_chk("basic vc hi", 3'd2, 16'h0007);
        rd_chk("basic vc mid", 3'd3, 16'h0080);
        rd_chk("basic vc lo", 3'd6, 16'h0002);

        // ---------------- four consecutive fetches ----------------
        vs_pulse();
        for (int i = 0; i < 4; i++)
            run_period(1'b1, int'($urandom_range(0, 7)), -1, 16'($urandom));
        chk("seq mem_addr", 32'(mem_addr), 32'h03C003);

        // ---------------- underrun ----------------
        run_period(1'b1, -1, -1, 16'h1234);
        chk("under shifter", 32'(shifter_data), 32'd0);
        rd_chk("under flag", 3'd5, 16'h0001);
        wr(3'd5, 16'($urandom));
        rd_chk("under clr", 3'd5, 16'h0000);

        // ---------------- vsync coincident with ack ----------------
        run_period(1'b1, 4, 4, 16'h5A5A);
        rd_chk("vs+ack vc mid", 3'd3, 16'h0080);
        rd_chk("vs+ack vc lo", 3'd6, 16'h0000);

        // base write does not touch vcount until vsync
        wr(3'd0, 16'h0015);
        rd_chk("base no vc", 3'd2, 16'h0007);

        // ---------------- low base register ----------------
        wr(3'd4, 16'h00FE);
        rd_chk("base lo", 3'd4, LO_EN ? 16'h00FE : 16'h0000);

        // ---------------- randomized periods ----------------
        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                int r;
                r = int'($urandom_range(0, 2));
                wr((r == 0) ? 3'd0 : (r == 1) ? 3'd1 : 3'd4, 16'($urandom));
            end
            if ($urandom_range(0, 5) == 0) vs_pulse();
            run_period($urandom_range(0, 3) != 0,
                       int'($urandom_range(0, 10)) - 1,
                       ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 14)) : -1,
                       16'($urandom));
            if ($urandom_range(0, 4) == 0) begin
                rd_chk("rand status", 3'd5, exp_rd(5));
                wr(3'd5, 16'h0000);
            end
        end
        rd_all("rand end");

        // ---------------- reset during REQ ----------------
        goto15();
        de = 1'b1;
        tick();
        chk("pre-rst mem_req", 32'(mem_req), 32'd1);
        tick();
        reset = 1'b1;
        slot  = 0;
        mem_ack  = 1'b1;
        mem_data = 16'hBEEF;
        tick();
        chk("rst mid mem_req", 32'(mem_req), 32'd0);
        chk("rst mid load", 32'(load), 32'd1);
        chk("rst mid shifter", 32'(shifter_data), 32'd0);
        mem_ack = 1'b0;
        de      = 1'b0;
        reset   = 1'b0;
        m_vc = 0; m_base = 0; m_sh = 16'h0; m_under = 1'b0;
        rd_all("post rst");

        // one clean fetch after reset
        run_period(1'b1, 2, -1, 16'hC3C3);
        rd_chk("post rst vc lo", 3'd6, 16'h0002);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
